// File: rtl/vga_draw_pkg.sv
// Shared screen geometry defaults and the drawer state encoding.
package vga_draw_pkg;
   localparam int DEF_X_W     = 8;
   localparam int DEF_Y_W     = 7;
   localparam int DEF_COLOR_W = 24;
   localparam int DEF_XMAX    = 160;
   localparam int DEF_YMAX    = 120;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } draw_state_t;
endpackage

// File: rtl/rect_fill_drawer_raster_counter.sv
// Nested x/y raster counter: x runs fastest over [x0, x_end), then y steps.
module raster_counter
   import vga_draw_pkg::*;
#(
   parameter int X_W = DEF_X_W,
   parameter int Y_W = DEF_Y_W
) (
   input  logic           clk,
   input  logic           srst,
   input  logic           i_load,
   input  logic [X_W-1:0] i_x0,
   input  logic [Y_W-1:0] i_y0,
   input  logic [X_W:0]   i_x_end,
   input  logic [Y_W:0]   i_y_end,
   input  logic           i_advance,
   output logic [X_W-1:0] o_x,
   output logic [Y_W-1:0] o_y,
   output logic           o_last
);
   localparam logic [X_W:0]   X_ONE_W = 1;
   localparam logic [Y_W:0]   Y_ONE_W = 1;
   localparam logic [X_W-1:0] X_ONE   = 1;
   localparam logic [Y_W-1:0] Y_ONE   = 1;

   logic [X_W-1:0] r_x;
   logic [X_W-1:0] r_x0;
   logic [Y_W-1:0] r_y;
   logic [X_W:0]   r_x_end;
   logic [Y_W:0]   r_y_end;
   logic           w_row_end;
   logic           w_col_end;

   // Compare in the widened domain so an end of XMAX/YMAX never wraps.
   assign w_row_end = (({1'b0, r_x} + X_ONE_W) == r_x_end);
   assign w_col_end = (({1'b0, r_y} + Y_ONE_W) == r_y_end);
   assign o_last    = w_row_end && w_col_end;
   assign o_x       = r_x;
   assign o_y       = r_y;

   always_ff @(posedge clk) begin
      if (srst) begin
         r_x     <= '0;
         r_x0    <= '0;
         r_y     <= '0;
         r_x_end <= '0;
         r_y_end <= '0;
      end else if (i_load) begin
         r_x     <= i_x0;
         r_x0    <= i_x0;
         r_y     <= i_y0;
         r_x_end <= i_x_end;
         r_y_end <= i_y_end;
      end else if (i_advance) begin
         if (w_row_end) begin
            r_x <= r_x0;
            r_y <= r_y + Y_ONE;
         end else begin
            r_x <= r_x + X_ONE;
         end
      end
   end
endmodule

// File: rtl/rect_fill_drawer.sv
// Clipped solid-rectangle / full-screen-clear pixel generator feeding a VGA plot port.
module rect_fill_drawer
   import vga_draw_pkg::*;
#(
   parameter int X_W     = DEF_X_W,
   parameter int Y_W     = DEF_Y_W,
   parameter int COLOR_W = DEF_COLOR_W,
   parameter int XMAX    = DEF_XMAX,
   parameter int YMAX    = DEF_YMAX
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   input  logic               clear,
   input  logic [X_W-1:0]     x0,
   input  logic [Y_W-1:0]     y0,
   input  logic [X_W-1:0]     w,
   input  logic [Y_W-1:0]     h,
   input  logic [COLOR_W-1:0] color,
   output logic               busy,
   output logic               done,
   output logic [X_W-1:0]     VGA_X,
   output logic [Y_W-1:0]     VGA_Y,
   output logic [COLOR_W-1:0] VGA_COLOR,
   output logic               plot
);
   localparam logic [X_W:0] L_XMAX = (X_W+1)'(XMAX);
   localparam logic [Y_W:0] L_YMAX = (Y_W+1)'(YMAX);

   draw_state_t        r_state;
   draw_state_t        w_state_next;
   logic [X_W:0]       w_x_sum;
   logic [Y_W:0]       w_y_sum;
   logic [X_W-1:0]     w_x_start;
   logic [Y_W-1:0]     w_y_start;
   logic [X_W:0]       w_x_end;
   logic [Y_W:0]       w_y_end;
   logic               w_zero;
   logic               w_accept;
   logic               w_load;
   logic               w_advance;
   logic               w_last;
   logic               w_busy_next;
   logic               w_done_next;
   logic               w_plot_next;
   logic               r_busy;
   logic               r_done;
   logic               r_plot;
   logic [COLOR_W-1:0] r_color;

   always_comb begin
      w_x_sum   = {1'b0, x0} + {1'b0, w};
      w_y_sum   = {1'b0, y0} + {1'b0, h};
      w_x_start = x0;
      w_y_start = y0;
      w_x_end   = (w_x_sum > L_XMAX) ? L_XMAX : w_x_sum;
      w_y_end   = (w_y_sum > L_YMAX) ? L_YMAX : w_y_sum;
      w_zero    = (w == '0) || (h == '0) ||
                  ({1'b0, x0} >= L_XMAX) || ({1'b0, y0} >= L_YMAX);
      if (clear) begin
         w_x_start = '0;
         w_y_start = '0;
         w_x_end   = L_XMAX;
         w_y_end   = L_YMAX;
         w_zero    = 1'b0;
      end
   end

   assign w_accept  = (r_state == IDLE) && start;
   assign w_load    = w_accept && !w_zero;
   assign w_advance = (r_state == DRAW) && !w_last;

   raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_raster (
      .clk       (CLOCK_50),
      .srst      (reset),
      .i_load    (w_load),
      .i_x0      (w_x_start),
      .i_y0      (w_y_start),
      .i_x_end   (w_x_end),
      .i_y_end   (w_y_end),
      .i_advance (w_advance),
      .o_x       (VGA_X),
      .o_y       (VGA_Y),
      .o_last    (w_last)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = w_zero ? DONE : DRAW;
         DRAW:    if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they appear registered with it.
   always_comb begin
      w_busy_next = (w_state_next != IDLE);
      w_done_next = (w_state_next == DONE);
      w_plot_next = (w_state_next == DRAW);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_plot  <= 1'b0;
         r_color <= '0;
      end else begin
         r_busy <= w_busy_next;
         r_done <= w_done_next;
         r_plot <= w_plot_next;
         if (w_accept) r_color <= color;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign plot      = r_plot;
   assign VGA_COLOR = r_color;
endmodule

// File: doc/rect_fill_drawer.md
# rect_fill_drawer

Pixel-generation stage that sits directly upstream of the DESim VGA plot interface (VGA_X/VGA_Y/VGA_COLOR/plot). On a start request it rasters a solid axis-aligned rectangle, or the whole 160×120 screen in clear mode, emitting one pixel write per clock. Every write is clipped to the screen. It replaces hand-written per-demo drawing counters in VGA demos.

## Interface
Parameters:
- X_W, 8, x coordinate / width bits
- Y_W, 7, y coordinate / height bits
- COLOR_W, 24, pixel colour bits
- XMAX, 160, screen width in pixels
- YMAX, 120, screen height in pixels

Ports (one clock; reset is synchronous and active-high):
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- clear  in  1  sampled with start; 1 = fill full screen, ignore x0/y0/w/h
- x0  in  X_W  rectangle left column
- y0  in  Y_W  rectangle top row
- w  in  X_W  width in pixels
- h  in  Y_W  height in pixels
- color  in  COLOR_W  fill colour
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse when the operation finishes
- VGA_X  out  X_W  pixel column
- VGA_Y  out  Y_W  pixel row
- VGA_COLOR  out  COLOR_W  pixel colour
- plot  out  1  write strobe; VGA_X/VGA_Y/VGA_COLOR are valid when high

## Operation
- States: IDLE, DRAW, DONE.
- IDLE → DRAW when start=1 and the clipped area is non-zero.
- IDLE → DONE when start=1 and the clipped area is zero.
- DRAW → DONE after the last pixel. DONE → IDLE unconditionally.
- On accept, latch operands and colour. Later input changes have no effect until the next accept.
- Clip computation uses X_W+1 / Y_W+1 bits to avoid overflow:
  - x_end = min(x0+w, XMAX); y_end = min(y0+h, YMAX).
  - Area is zero if w=0, h=0, x0≥XMAX or y0≥YMAX.
- Clear mode: x0=0, y0=0, x_end=XMAX, y_end=YMAX.
- Raster order: x increments fastest from x0 to x_end-1. At wrap, x returns to x0 and y increments. The last pixel is (x_end-1, y_end-1).
- A start while busy=1 is ignored. It is neither queued nor latched.
- done and plot are never high in the same cycle.

## Timing
- Reset values: busy=0, done=0, plot=0, VGA_X=0, VGA_Y=0, VGA_COLOR=0, state=IDLE.
- All outputs are registered.
- start sampled at edge k:
  - first pixel has plot=1 at edge k+1;
  - N pixels occupy cycles k+1..k+N;
  - done=1 at k+N+1;
  - the next start is accepted at edge k+N+2 or later.
- Zero-area request: done=1 at k+1, no plot, busy=1 for that single cycle.
- Throughput: exactly one pixel per cycle in DRAW, with no bubbles at row wrap.
- Reset asserted mid-DRAW:
  - next cycle is IDLE with all outputs at reset values;
  - the partial rectangle is abandoned;
  - no done pulse is emitted.
- Outside DRAW, plot=0. VGA_X/VGA_Y hold their last value.

## Structure
- Shared package `vga_draw_pkg`: XMAX/YMAX defaults, X_W/Y_W/COLOR_W defaults, the state enum (IDLE/DRAW/DONE).
- One natural sub-module, `raster_counter`: nested x/y counter.
  - Inputs: load with x0/y0/x_end/y_end, and advance.
  - Outputs: x, y, and a `last` flag.
- The top-level FSM, clip logic and output registers stay in rect_fill_drawer.

## Test plan
- Basic rectangle: reset, then start with x0=10, y0=5, w=2, h=2, color=24'hFF0000 at cycle 0.
  - Required: plots (10,5), (11,5), (10,6), (11,6) on cycles 1–4 with colour FF0000.
  - done on cycle 5; busy low on cycle 6.
- Zero area: w=0, h=7 → done on cycle 1, plot never asserted. Repeat with x0=200 → same response.
- Right-edge clip: x0=158, y0=119, w=4, h=3 → exactly two plots, (158,119) and (159,119), then done.
- Clear mode: clear=1, color=24'h0000FF.
  - Required: 19200 plots covering every (x,y) exactly once in raster order.
  - First plot (0,0), last plot (159,119), done on cycle 19201.
- Start while busy: a second start with different operands mid-DRAW is ignored. Output matches the first rectangle only, and a single done pulse occurs.
- Reset mid-draw: assert reset during pixel 3 of a 4×4 fill.
  - Next cycle: plot=0, busy=0, done=0.
  - A new start after reset release draws correctly from its own x0/y0.
